// File: rtl/hog_window_serializer.sv
// Round-robin window arbiter and word serializer between the HOG
// pyramid level channels and the SVM classifier input stream.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   detection_window    LEVELS windows, level k at [k*WINDOW_WIDTH +: WINDOW_WIDTH]
//   window_valid/ready  per-level window handshake, ready is one-hot or zero
//   out_data/out_level  current word (LS word first) and its scale level
//   out_first/out_last  word 0 / word WORDS-1 markers
//   out_valid/ready     downstream word handshake
module hog_window_serializer #(
  parameter int WINDOW_WIDTH = 1152,
  parameter int LEVELS       = 7,
  parameter int OUT_WIDTH    = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WINDOW_WIDTH*LEVELS-1:0] detection_window,
  input  logic [LEVELS-1:0]              window_valid,
  output logic [LEVELS-1:0]              window_ready,
  output logic [OUT_WIDTH-1:0]           out_data,
  output logic [3:0]                     out_level,
  output logic                           out_first,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int WORDS = WINDOW_WIDTH / OUT_WIDTH;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              ptr_q, ptr_d;
  logic [3:0]              level_q, level_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WINDOW_WIDTH-1:0] shift_q, shift_d;
  logic                    valid_q, valid_d;
  logic                    first_q, first_d;
  logic                    last_q, last_d;

  logic [3:0]              grant;
  logic                    grant_vld;
  logic [2*LEVELS-1:0]     rot;
  logic [4:0]              sum;

  // Rotate requests so offset 0 is the pointer; the smallest set offset
  // wins, scanned from the top so the last hit is the lowest offset.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    sum       = '0;
    rot       = {window_valid, window_valid} >> ptr_q;
    for (int k = LEVELS - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, ptr_q} + 5'(k);
        if (sum >= 5'(LEVELS)) begin
          sum = sum - 5'(LEVELS);
        end
        grant     = sum[3:0];
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    window_ready = '0;
    if (state_q == IDLE && grant_vld) begin
      window_ready = LEVELS'(1) << grant;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    valid_d = valid_q;
    first_d = first_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          shift_d = detection_window[int'(grant)*WINDOW_WIDTH +: WINDOW_WIDTH];
          level_d = grant;
          cnt_d   = '0;
          ptr_d   = (grant == 4'(LEVELS - 1)) ? 4'd0 : grant + 4'd1;
          state_d = SEND;
          valid_d = 1'b1;
          first_d = 1'b1;
          last_d  = (WORDS == 1);
        end
      end
      SEND: begin
        if (out_ready) begin
          shift_d = shift_q >> OUT_WIDTH;
          first_d = 1'b0;
          if (cnt_q == LAST_CNT) begin
            // One bubble cycle in IDLE before the next grant.
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            last_d = (cnt_d == LAST_CNT);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      level_q <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign out_data  = shift_q[OUT_WIDTH-1:0];
  assign out_level = level_q;
  assign out_first = first_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_hog_window_serializer.sv
// Scoreboard bench for hog_window_serializer: per-level window sources,
// a round-robin reference model and a word monitor on the output stream.
module tb_hog_window_serializer;

  localparam int WW    = 1152;
  localparam int L     = 7;
  localparam int OW    = 32;
  localparam int WORDS = WW / OW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [WW*L-1:0] detection_window = '0;
  logic [L-1:0]    window_valid = '0;
  logic [L-1:0]    window_ready;
  logic [OW-1:0]   out_data;
  logic [3:0]      out_level;
  logic            out_first;
  logic            out_last;
  logic            out_valid;
  logic            out_ready = 1'b0;

  hog_window_serializer #(
    .WINDOW_WIDTH(WW),
    .LEVELS(L),
    .OUT_WIDTH(OW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .detection_window(detection_window),
    .window_valid(window_valid),
    .window_ready(window_ready),
    .out_data(out_data),
    .out_level(out_level),
    .out_first(out_first),
    .out_last(out_last),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] d;
    logic [3:0]    lvl;
    logic          f;
    logic          l;
  } exp_t;

  exp_t          sb[$];
  exp_t          e;
  logic [WW-1:0] src_mem[L][8];
  int            src_wr[L];
  int            src_rd[L];

  int errors = 0;
  int checks = 0;

  int  m_ptr = 0;
  bit  m_idle = 1'b1;
  int  grants[$];
  int  gcyc[$];
  int  cyc = 0;
  int  win_words = 0;
  int  ready_cycles = 0;
  bit  rnd_mode = 1'b0;

  logic [WW-1:0] mw;
  logic [L-1:0]  er;
  int            g;
  bit            prev_v = 1'b0;
  bit            prev_r = 1'b0;
  logic [37:0]   prev_o;
  logic [37:0]   cur_o;
  logic [WW-1:0] w;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit src_empty();
    for (int k = 0; k < L; k++) begin
      if (src_rd[k] < src_wr[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Reference model and output monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    cyc++;
    cur_o = {out_data, out_level, out_first, out_last};
    if (rst) begin
      sb.delete();
      m_idle    = 1'b1;
      m_ptr     = 0;
      prev_v    = 1'b0;
      win_words = 0;
    end else begin
      er = '0;
      g  = -1;
      if (m_idle) begin
        for (int k = 0; k < L; k++) begin
          if (g < 0 && window_valid[(m_ptr + k) % L]) g = (m_ptr + k) % L;
        end
      end
      if (g >= 0) er[g] = 1'b1;
      if (|window_ready) ready_cycles++;
      chk("window_ready", 64'(window_ready), 64'(er));
      chk("out_valid", 64'(out_valid), 64'(!m_idle));
      if (prev_v && !prev_r) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_hold", 64'(cur_o), 64'(prev_o));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got %0h expected none", cur_o);
        end else begin
          e = sb.pop_front();
          chk("word", 64'(cur_o), 64'({e.d, e.lvl, e.f, e.l}));
          win_words++;
          if (e.l) begin
            m_idle    = 1'b1;
            win_words = 0;
          end
        end
      end
      if (g >= 0) begin
        mw = src_mem[g][src_rd[g] & 7];
        src_rd[g]++;
        for (int i = 0; i < WORDS; i++) begin
          sb.push_back('{mw[i*OW +: OW], 4'(g), i == 0, i == WORDS - 1});
        end
        m_ptr  = (g + 1) % L;
        m_idle = 1'b0;
        grants.push_back(g);
        gcyc.push_back(cyc);
      end
      prev_v = out_valid;
      prev_r = out_ready;
      prev_o = cur_o;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < L; k++) begin
      window_valid[k] = (src_rd[k] < src_wr[k]);
      if (window_valid[k]) detection_window[k*WW +: WW] = src_mem[k][src_rd[k] & 7];
      else                 detection_window[k*WW +: WW] = '0;
    end
    out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic push(int k, logic [WW-1:0] data);
    src_mem[k][src_wr[k] & 7] = data;
    src_wr[k]++;
  endtask

  task automatic drain(int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(sb.size() == 0 && m_idle && src_empty()) && n < budget);
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d words left expected 0", sb.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic rand_window();
    for (int i = 0; i < WORDS; i++) w[i*OW +: OW] = $urandom;
  endtask

  initial begin
    int n;
    for (int k = 0; k < L; k++) begin
      src_wr[k] = 0;
      src_rd[k] = 0;
    end
    repeat (3) step();
    chk("rst_ready", 64'(window_ready), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_level", 64'(out_level), 64'd0);
    chk("rst_first", 64'(out_first), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    rst = 1'b0;

    // Level 0, word i = i, full throughput
    for (int i = 0; i < WORDS; i++) w[i*OW +: OW] = 32'(i);
    ready_cycles = 0;
    grants.delete();
    push(0, w);
    drain(200);
    chk("t1_ready_cycles", 64'(ready_cycles), 64'd1);
    chk("t1_grants", 64'(grants.size()), 64'd1);

    // Same window under random backpressure
    rnd_mode = 1'b1;
    push(0, w);
    drain(1000);
    rnd_mode = 1'b0;
    rand_window();
    rnd_mode = 1'b1;
    push(3, w);
    rand_window();
    push(6, w);
    drain(1000);
    rnd_mode = 1'b0;

    // All levels valid from reset: order 0..6,0, 37 cycles apart
    do_reset();
    grants.delete();
    gcyc.delete();
    for (int k = 0; k < L; k++) begin
      rand_window();
      push(k, w);
    end
    rand_window();
    push(0, w);
    drain(1000);
    chk("t3_count", 64'(grants.size()), 64'(L + 1));
    for (int i = 0; i < grants.size(); i++) begin
      chk("t3_order", 64'(grants[i]), 64'(i % L));
      if (i > 0) chk("t3_spacing", 64'(gcyc[i] - gcyc[i-1]), 64'(WORDS + 1));
    end

    // Pointer behaviour after granting level 2
    do_reset();
    grants.delete();
    rand_window();
    push(2, w);
    n = 0;
    while (grants.size() == 0 && n < 20) begin
      step();
      n++;
    end
    rand_window();
    push(1, w);
    drain(500);
    rand_window();
    push(1, w);
    rand_window();
    push(5, w);
    drain(500);
    chk("t4_count", 64'(grants.size()), 64'd4);
    if (grants.size() == 4) begin
      chk("t4_g0", 64'(grants[0]), 64'd2);
      chk("t4_g1", 64'(grants[1]), 64'd1);
      chk("t4_g2", 64'(grants[2]), 64'd5);
      chk("t4_g3", 64'(grants[3]), 64'd1);
    end

    // Reset during word 10 of a level 2 window
    do_reset();
    for (int i = 0; i < WORDS; i++) w[i*OW +: OW] = 32'(i + 100);
    push(2, w);
    n = 0;
    while (win_words != 10 && n < 100) begin
      step();
      n++;
    end
    chk("t5_reached_word10", 64'(win_words), 64'd10);
    chk("t5_pre_level", 64'(out_level), 64'd2);
    rst = 1'b1;
    step();
    chk("t5_valid", 64'(out_valid), 64'd0);
    chk("t5_ready", 64'(window_ready), 64'd0);
    chk("t5_level", 64'(out_level), 64'd0);
    rst = 1'b0;
    grants.delete();
    rand_window();
    push(4, w);
    rand_window();
    push(0, w);
    drain(500);
    chk("t5_first_grant", 64'(grants.size() > 0 ? grants[0] : -1), 64'd0);

    // Idle for 100 cycles
    for (int i = 0; i < 100; i++) begin
      step();
      chk("t6_idle", 64'({window_ready, out_valid}), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
